uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync2.sv | 29 ++
 rtl/uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receive path.
//   uart_state_t : receiver FSM state encoding
//   OVERSAMPLE   : baud ticks per bit
//   MID_CNT      : oversample count at the middle of the start bit
//   SAMPLE_CNT   : oversample count at which data/parity/stop bits are sampled
//   MAX_DATA_W   : widest supported data word
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam int          OVERSAMPLE = 16;
   localparam logic [3:0]  MID_CNT    = 4'd7;
   localparam logic [3:0]  SAMPLE_CNT = 4'd15;
   localparam int          MAX_DATA_W = 8;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2 -- two-flop synchronizer for an asynchronous, idle-high line.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (both flops reset to 1 = line idle)
//   d     : asynchronous input
//   q     : synchronized output
module uart_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic sync_p0;
   logic sync_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         sync_p0 <= d;
         sync_p1 <= sync_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 16x oversampling UART receiver, LSB-first, one stop bit.
// Parameters:
//   DATA_BITS  : data bits per frame (5..8)
//   PARITY_ODD : parity sense when parity is compiled in (0 even, 1 odd)
// Ports:
//   clk           : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   rx_baud_tick  : one-clk strobe at 16x baud
//   rx            : asynchronous serial input, idle high
//   rx_data       : last good word, LSB-aligned, unused upper bits 0
//   rx_valid      : one-clk pulse when rx_data is updated
//   rx_frame_err  : one-clk pulse when the stop bit is sampled low
//   rx_parity_err : one-clk pulse on parity mismatch (0 without parity)
//   rx_busy       : high whenever the FSM is not idle
// Optional feature macro: UART_RX_PARITY_EN (one parity bit after the data).
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_baud_tick,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_parity_err,
   output logic       rx_busy
);

   logic                  rx_s;
   uart_state_t           state, state_nxt;
   logic [3:0]            os_cnt, os_cnt_nxt;
   logic [2:0]            bit_cnt, bit_cnt_nxt;
   logic [MAX_DATA_W-1:0] shift, shift_nxt;
   logic                  load;
   logic                  valid_nxt;
   logic                  ferr_nxt;
   logic                  frame_ok;
`ifdef UART_RX_PARITY_EN
   logic                  par_bad, par_bad_nxt;
   logic                  perr_nxt;
   logic                  perr_q;
   logic                  par_mismatch;
`endif

   uart_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

`ifdef UART_RX_PARITY_EN
   // Total ones over data plus parity bit must equal the parity sense.
   assign par_mismatch = (^shift) ^ rx_s ^ PARITY_ODD;
   // A frame with bad parity still runs through STOP but is never loaded.
   assign frame_ok     = !par_bad;
`else
   assign frame_ok     = 1'b1;
`endif

   always_comb begin
      state_nxt   = state;
      os_cnt_nxt  = os_cnt;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift;
      load        = 1'b0;
      valid_nxt   = 1'b0;
      ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_nxt = par_bad;
      perr_nxt    = 1'b0;
`endif
      if (rx_baud_tick) begin
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_nxt  = ST_START;
                  os_cnt_nxt = '0;
               end
            end
            ST_START: begin
               if (os_cnt == MID_CNT) begin
                  // Mid start bit: a high line here was only a glitch.
                  os_cnt_nxt  = '0;
                  bit_cnt_nxt = '0;
                  state_nxt   = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
                  par_bad_nxt = 1'b0;
`endif
               end else begin
                  os_cnt_nxt = os_cnt + 4'd1;
               end
            end
            ST_DATA: begin
               // Counter wraps 15 -> 0, so each bit spans exactly 16 ticks.
               os_cnt_nxt = os_cnt + 4'd1;
               if (os_cnt == SAMPLE_CNT) begin
                  // Shift in at the top of the word so it ends LSB-aligned.
                  shift_nxt                = shift >> 1;
                  shift_nxt[DATA_BITS-1]   = rx_s;
                  bit_cnt_nxt              = bit_cnt + 3'd1;
                  if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state_nxt = ST_PARITY;
`else
                     state_nxt = ST_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               os_cnt_nxt = os_cnt + 4'd1;
               if (os_cnt == SAMPLE_CNT) begin
                  perr_nxt    = par_mismatch;
                  par_bad_nxt = par_mismatch;
                  state_nxt   = ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               os_cnt_nxt = os_cnt + 4'd1;
               if (os_cnt == SAMPLE_CNT) begin
                  // Leaving at mid-stop lets a following start bit be caught at once.
                  state_nxt  = ST_IDLE;
                  os_cnt_nxt = '0;
                  if (rx_s) begin
                     load      = frame_ok;
                     valid_nxt = frame_ok;
                  end else begin
                     ferr_nxt  = 1'b1;
                  end
               end
            end
            default: begin
               state_nxt  = ST_IDLE;
               os_cnt_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         os_cnt       <= '0;
         bit_cnt      <= '0;
         shift        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         os_cnt       <= os_cnt_nxt;
         bit_cnt      <= bit_cnt_nxt;
         shift        <= shift_nxt;
         rx_valid     <= valid_nxt;
         rx_frame_err <= ferr_nxt;
         if (load) begin
            rx_data <= shift;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bad <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         par_bad <= par_bad_nxt;
         perr_q  <= perr_nxt;
      end
   end

   assign rx_parity_err = perr_q;
`else
   // Parity sense is irrelevant without a parity bit; the output is a constant 0.
   assign rx_parity_err = 1'b0 & PARITY_ODD;
`endif

   assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx at 50 MHz / 115200 baud
// (one baud tick every 27 clk, 16 ticks = 432 clk per bit).
// Set UART_RX_PARITY_EN to include the parity-frame sequences.
module tb_uart_rx;

   localparam int DATA_BITS = 8;
   localparam int TICK_DIV  = 27;
   localparam int BIT_CLKS  = 16 * TICK_DIV;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_baud_tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_parity_err;
   logic       rx_busy;

   uart_rx #(.DATA_BITS(DATA_BITS)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_baud_tick  (rx_baud_tick),
      .rx            (rx),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err),
      .rx_busy       (rx_busy)
   );

   always #10 clk = ~clk;

   // Baud tick generator; tick_en lets a sequence remove ticks entirely.
   bit tick_en = 1'b1;
   int tcnt    = 0;
   initial begin
      rx_baud_tick = 1'b0;
      forever begin
         @(negedge clk);
         if (tcnt == TICK_DIV - 1) tcnt = 0;
         else                      tcnt = tcnt + 1;
         rx_baud_tick = tick_en && (tcnt == TICK_DIV - 1);
      end
   end

   // Pulse monitor: counts pulses, records each received word, flags pulses wider than one clk.
   int         n_valid   = 0;
   int         n_ferr    = 0;
   int         n_perr    = 0;
   int         width_err = 0;
   logic [7:0] hist [256];
   logic       pv = 1'b0, pf = 1'b0, pp = 1'b0;
   always @(negedge clk) begin
      if (rx_valid) begin
         hist[n_valid % 256] = rx_data;
         n_valid = n_valid + 1;
      end
      if (rx_frame_err)  n_ferr = n_ferr + 1;
      if (rx_parity_err) n_perr = n_perr + 1;
      if ((pv && rx_valid) || (pf && rx_frame_err) || (pp && rx_parity_err))
         width_err = width_err + 1;
      pv = rx_valid;
      pf = rx_frame_err;
      pp = rx_parity_err;
   end

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      idle_clks(BIT_CLKS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(^d);
`endif
      drive_bit(stop);
      rx = 1'b1;
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop;
      int         exp_v;
      int         exp_f;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vt [5];

   initial begin
      int v0, f0, p0;
      vt[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
      vt[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
      vt[2] = '{8'h01, 1'b1, 1, 0, 8'h01};
      vt[3] = '{8'h80, 1'b1, 1, 0, 8'h80};
      vt[4] = '{8'h5A, 1'b0, 0, 1, 8'h80};

      // Reset state
      rst_n = 1'b0;
      rx    = 1'b1;
      idle_clks(5);
      check("reset_rx_data",   32'(rx_data),       32'h0);
      check("reset_valid",     32'(rx_valid),      32'h0);
      check("reset_frame_err", 32'(rx_frame_err),  32'h0);
      check("reset_par_err",   32'(rx_parity_err), 32'h0);
      check("reset_busy",      32'(rx_busy),       32'h0);
      rst_n = 1'b1;
      idle_clks(100);

      // Table-driven frames: good data and bad-stop frames
      for (int i = 0; i < 5; i++) begin
         v0 = n_valid; f0 = n_ferr; p0 = n_perr;
         send_frame(vt[i].d, vt[i].stop);
         idle_clks(BIT_CLKS);
         check($sformatf("vec%0d_valid_cnt", i), 32'(n_valid - v0), 32'(vt[i].exp_v));
         check($sformatf("vec%0d_ferr_cnt", i),  32'(n_ferr - f0),  32'(vt[i].exp_f));
         check($sformatf("vec%0d_perr_cnt", i),  32'(n_perr - p0),  32'h0);
         check($sformatf("vec%0d_rx_data", i),   32'(rx_data),      32'(vt[i].exp_data));
         check($sformatf("vec%0d_busy", i),      32'(rx_busy),      32'h0);
      end

      // Back-to-back frames with a single stop bit
      v0 = n_valid; f0 = n_ferr;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle_clks(BIT_CLKS);
      check("b2b_valid_cnt", 32'(n_valid - v0), 32'd2);
      check("b2b_ferr_cnt",  32'(n_ferr - f0),  32'd0);
      check("b2b_first",     32'(hist[v0 % 256]),       32'h00);
      check("b2b_second",    32'(hist[(v0 + 1) % 256]), 32'hFF);

      // Start-bit glitch: low for 4 ticks only
      v0 = n_valid; f0 = n_ferr;
      rx = 1'b0;
      idle_clks(60);
      check("glitch_busy_high", 32'(rx_busy), 32'h1);
      idle_clks(4 * TICK_DIV - 60);
      rx = 1'b1;
      idle_clks(BIT_CLKS);
      check("glitch_busy_low",  32'(rx_busy),       32'h0);
      check("glitch_valid_cnt", 32'(n_valid - v0),  32'd0);
      check("glitch_ferr_cnt",  32'(n_ferr - f0),   32'd0);

      // No ticks: line activity must be ignored
      tick_en = 1'b0;
      idle_clks(2);
      rx = 1'b0;
      idle_clks(200);
      check("notick_busy", 32'(rx_busy), 32'h0);
      rx = 1'b1;
      idle_clks(10);
      tick_en = 1'b1;
      idle_clks(3 * TICK_DIV);
      check("notick_busy_after", 32'(rx_busy), 32'h0);

      // Reset in the middle of bit 3 of 0x55, then receive 0x81
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      rx = 1'b0;
      idle_clks(BIT_CLKS / 2);
      check("midframe_busy", 32'(rx_busy), 32'h1);
      rst_n = 1'b0;
      rx    = 1'b1;
      idle_clks(5);
      check("rst_mid_rx_data", 32'(rx_data),       32'h0);
      check("rst_mid_valid",   32'(rx_valid),      32'h0);
      check("rst_mid_ferr",    32'(rx_frame_err),  32'h0);
      check("rst_mid_perr",    32'(rx_parity_err), 32'h0);
      check("rst_mid_busy",    32'(rx_busy),       32'h0);
      v0 = n_valid; f0 = n_ferr; p0 = n_perr;
      rst_n = 1'b1;
      idle_clks(2 * BIT_CLKS);
      check("rst_after_no_pulse", 32'((n_valid - v0) + (n_ferr - f0) + (n_perr - p0)), 32'd0);
      send_frame(8'h81, 1'b1);
      idle_clks(BIT_CLKS);
      check("rst_next_valid_cnt", 32'(n_valid - v0), 32'd1);
      check("rst_next_rx_data",   32'(rx_data),      32'h81);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: even parity bit should be 1, send 0
      v0 = n_valid; f0 = n_ferr; p0 = n_perr;
      drive_bit(1'b0);
      for (int i = 0; i < DATA_BITS; i++) drive_bit(1'(8'h07 >> i));
      drive_bit(1'b0);
      drive_bit(1'b1);
      idle_clks(BIT_CLKS);
      check("par_perr_cnt",  32'(n_perr - p0),  32'd1);
      check("par_valid_cnt", 32'(n_valid - v0), 32'd0);
      check("par_ferr_cnt",  32'(n_ferr - f0),  32'd0);
      check("par_rx_data",   32'(rx_data),      32'h81);

      // Bad parity and bad stop together
      v0 = n_valid; f0 = n_ferr; p0 = n_perr;
      drive_bit(1'b0);
      for (int i = 0; i < DATA_BITS; i++) drive_bit(1'(8'h07 >> i));
      drive_bit(1'b0);
      drive_bit(1'b0);
      rx = 1'b1;
      idle_clks(BIT_CLKS);
      check("parstop_perr_cnt",  32'(n_perr - p0),  32'd1);
      check("parstop_ferr_cnt",  32'(n_ferr - f0),  32'd1);
      check("parstop_valid_cnt", 32'(n_valid - v0), 32'd0);
`endif

      check("pulse_width_errs", 32'(width_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1);
   end

endmodule
